// File: rtl/vga_pkg.sv
// Shared 1024x768 @ 60 Hz raster constants and the sync polarity used by every video stage.
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int CELL_SIZE = 32;
  localparam int GRID_COLS = 32;
  localparam int GRID_ROWS = 24;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int CELL_W  = 6;

  function automatic logic sync_level(input logic asserted, input logic active_lvl);
    return asserted ? active_lvl : ~active_lvl;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle driven by vga_timing_gen and consumed by the overlay stages.
// VGA_TIMING_CELL_EN adds the registered cell_x_out/cell_y_out grid coordinates.
interface vga_timing_gen_if;
  logic [15:0] hcount_out;
  logic [15:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic        frame_start;
  logic        game_tick;
`ifdef VGA_TIMING_CELL_EN
  logic [5:0]  cell_x_out;
  logic [5:0]  cell_y_out;

  modport master (
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           frame_start, game_tick, cell_x_out, cell_y_out
  );
  modport slave (
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           frame_start, game_tick, cell_x_out, cell_y_out
  );
`else
  modport master (
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           frame_start, game_tick
  );
  modport slave (
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           frame_start, game_tick
  );
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis with registered sync and blank decodes.
// Decodes come from the next count so they never skew against the counter.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   W        = 11,
  parameter int   ACTIVE   = 1024,
  parameter int   FP       = 24,
  parameter int   SYNC     = 136,
  parameter int   BP       = 160,
  parameter logic SYNC_LVL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_nxt,
  output logic         sync_q,
  output logic         blnk_q
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC - 1;

  logic [W-1:0] cnt_d;
  logic         sync_d;
  logic         blnk_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == W'(TOTAL - 1)) ? '0 : cnt_q + W'(1);
    end
    sync_d = sync_level((cnt_d >= W'(SYNC_START)) && (cnt_d <= W'(SYNC_END)), SYNC_LVL);
    blnk_d = (cnt_d >= W'(ACTIVE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sync_q <= ~SYNC_LVL;
      blnk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
      blnk_q <= blnk_d;
    end
  end

  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: H/V counters, syncs, blanks, frame_start and the periodic game_tick.
// Define VGA_TIMING_CELL_EN to also emit registered 32x32 cell coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int   H_FP        = vga_pkg::H_FP,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BP        = vga_pkg::H_BP,
  parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int   V_FP        = vga_pkg::V_FP,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BP        = vga_pkg::V_BP,
  parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE,
  parameter int   TICK_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  logic [H_CNT_W-1:0] h_q, h_nxt;
  logic [V_CNT_W-1:0] v_q, v_nxt;
  logic               hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic               v_en;

  // V only advances on the cycle H wraps back to column 0.
  assign v_en = (h_nxt == '0);

  vga_axis_counter #(
    .W(H_CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_LVL(SYNC_ACTIVE)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(1'b1),
    .cnt_q(h_q), .cnt_nxt(h_nxt), .sync_q(hsync_q), .blnk_q(hblnk_q)
  );

  vga_axis_counter #(
    .W(V_CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_LVL(SYNC_ACTIVE)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(v_en),
    .cnt_q(v_q), .cnt_nxt(v_nxt), .sync_q(vsync_q), .blnk_q(vblnk_q)
  );

  logic       frame_start_d, frame_start_q;
  logic       game_tick_d, game_tick_q;
  logic [7:0] frame_cnt_d, frame_cnt_q;
  logic       tick_hit;

  always_comb begin
    frame_start_d = (h_nxt == '0) && (v_nxt == '0);
    tick_hit      = (frame_cnt_q == 8'(TICK_FRAMES - 1));
    frame_cnt_d   = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = tick_hit ? 8'd0 : frame_cnt_q + 8'd1;
    end
    game_tick_d = frame_start_d && tick_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
      game_tick_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      frame_start_q <= frame_start_d;
      game_tick_q   <= game_tick_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga.hcount_out  = 16'(h_q);
  assign vga.vcount_out  = 16'(v_q);
  assign vga.hsync_out   = hsync_q;
  assign vga.vsync_out   = vsync_q;
  assign vga.hblnk_out   = hblnk_q;
  assign vga.vblnk_out   = vblnk_q;
  assign vga.frame_start = frame_start_q;
  assign vga.game_tick   = game_tick_q;

`ifdef VGA_TIMING_CELL_EN
  logic [CELL_W-1:0] cell_x_d, cell_x_q, cell_y_d, cell_y_q;

  always_comb begin
    cell_x_d = (h_nxt >= H_CNT_W'(H_ACTIVE)) ? '0 : CELL_W'(h_nxt / H_CNT_W'(CELL_SIZE));
    cell_y_d = (v_nxt >= V_CNT_W'(V_ACTIVE)) ? '0 : CELL_W'(v_nxt / V_CNT_W'(CELL_SIZE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_x_q <= '0;
      cell_y_q <= '0;
    end else begin
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
    end
  end

  assign vga.cell_x_out = cell_x_q;
  assign vga.cell_y_out = cell_y_q;
`else
  // Cell coordinates are not built; overlay stages derive their own.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a scaled-down raster (80x56 total) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = 80;
  localparam int VA = 48, VF = 2, VS = 3, VB = 3, VT = 56;
  localparam int TF = 3;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .TICK_FRAMES(TF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int th, input int tv);
    int n;
    n = 0;
    while (!(int'(vif.hcount_out) == th && int'(vif.vcount_out) == tv) && n < 2 * FRAME) begin
      step();
      n++;
    end
    checks++;
    if (!(int'(vif.hcount_out) == th && int'(vif.vcount_out) == tv)) begin
      errors++;
      $display("FAIL run_to: stuck at (%0d,%0d), wanted (%0d,%0d)",
               vif.hcount_out, vif.vcount_out, th, tv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) step();
    checks++;
    if (vif.hcount_out !== 16'd0 || vif.vcount_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got (%0d,%0d) expected (0,0)", vif.hcount_out, vif.vcount_out);
    end
    checks++;
    if ({vif.hsync_out, vif.vsync_out} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync: got %b expected 11", {vif.hsync_out, vif.vsync_out});
    end
    checks++;
    if ({vif.hblnk_out, vif.vblnk_out, vif.frame_start, vif.game_tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {vif.hblnk_out, vif.vblnk_out, vif.frame_start, vif.game_tick});
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (vif.hcount_out !== 16'd1 || vif.vcount_out !== 16'd0) begin
      errors++;
      $display("FAIL first_edge: got (%0d,%0d) expected (1,0)", vif.hcount_out, vif.vcount_out);
    end
    checks++;
    if ({vif.hsync_out, vif.vsync_out, vif.hblnk_out, vif.vblnk_out, vif.frame_start} !== 5'b11000) begin
      errors++;
      $display("FAIL first_edge_flags: got %b expected 11000",
               {vif.hsync_out, vif.vsync_out, vif.hblnk_out, vif.vblnk_out, vif.frame_start});
    end
  endtask

  task automatic test_line();
    int first_blnk, first_low, low_cnt;
    first_blnk = -1; first_low = -1; low_cnt = 0;
    for (int i = 2; i < HT; i++) begin
      step();
      if (vif.hblnk_out && first_blnk < 0) first_blnk = int'(vif.hcount_out);
      if (!vif.hsync_out) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(vif.hcount_out);
      end
    end
    checks++;
    if (first_blnk != 64) begin
      errors++;
      $display("FAIL hblnk_rise: got h=%0d expected h=64", first_blnk);
    end
    checks++;
    if (first_low != 68) begin
      errors++;
      $display("FAIL hsync_start: got h=%0d expected h=68", first_low);
    end
    checks++;
    if (low_cnt != 8) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected 8", low_cnt);
    end
    checks++;
    if (vif.hcount_out !== 16'd79 || vif.vcount_out !== 16'd0) begin
      errors++;
      $display("FAIL line_end: got (%0d,%0d) expected (79,0)", vif.hcount_out, vif.vcount_out);
    end
    step();
    checks++;
    if (vif.hcount_out !== 16'd0 || vif.vcount_out !== 16'd1 || vif.hblnk_out !== 1'b0) begin
      errors++;
      $display("FAIL h_wrap: got (%0d,%0d) hblnk=%b expected (0,1) hblnk=0",
               vif.hcount_out, vif.vcount_out, vif.hblnk_out);
    end
  endtask

  task automatic test_frame();
    int n_steps, vs_low, vb_high, fs_cnt;
    int fl_h, fl_v, ll_h, ll_v, vb_first_v, pre_h, pre_v;
    n_steps = (VT - 1) * HT;
    vs_low = 0; vb_high = 0; fs_cnt = 0;
    fl_h = -1; fl_v = -1; ll_h = -1; ll_v = -1; vb_first_v = -1; pre_h = -1; pre_v = -1;
    for (int i = 1; i <= n_steps; i++) begin
      step();
      if (!vif.vsync_out) begin
        vs_low++;
        if (fl_h < 0) begin fl_h = int'(vif.hcount_out); fl_v = int'(vif.vcount_out); end
        ll_h = int'(vif.hcount_out); ll_v = int'(vif.vcount_out);
      end
      if (vif.vblnk_out) begin
        vb_high++;
        if (vb_first_v < 0) vb_first_v = int'(vif.vcount_out);
      end
      if (vif.frame_start) fs_cnt++;
      if (i == n_steps - 1) begin pre_h = int'(vif.hcount_out); pre_v = int'(vif.vcount_out); end
    end
    checks++;
    if (vs_low != 3 * HT) begin
      errors++;
      $display("FAIL vsync_width: got %0d expected %0d", vs_low, 3 * HT);
    end
    checks++;
    if (fl_h != 0 || fl_v != 50 || ll_h != 79 || ll_v != 52) begin
      errors++;
      $display("FAIL vsync_span: got (%0d,%0d)..(%0d,%0d) expected (0,50)..(79,52)",
               fl_h, fl_v, ll_h, ll_v);
    end
    checks++;
    if (vb_high != 8 * HT || vb_first_v != 48) begin
      errors++;
      $display("FAIL vblnk: got %0d cycles from v=%0d expected 640 from v=48", vb_high, vb_first_v);
    end
    checks++;
    if (pre_h != 79 || pre_v != 55) begin
      errors++;
      $display("FAIL pre_wrap: got (%0d,%0d) expected (79,55)", pre_h, pre_v);
    end
    checks++;
    if (vif.hcount_out !== 16'd0 || vif.vcount_out !== 16'd0 || vif.vblnk_out !== 1'b0) begin
      errors++;
      $display("FAIL v_wrap: got (%0d,%0d) vblnk=%b expected (0,0) vblnk=0",
               vif.hcount_out, vif.vcount_out, vif.vblnk_out);
    end
    checks++;
    if (fs_cnt != 1 || vif.frame_start !== 1'b1 || vif.game_tick !== 1'b0) begin
      errors++;
      $display("FAIL first_frame_start: got count=%0d fs=%b gt=%b expected count=1 fs=1 gt=0",
               fs_cnt, vif.frame_start, vif.game_tick);
    end
  endtask

  task automatic test_game_tick();
    int fs_n, gt_n, stray, mask;
    fs_n = 1; gt_n = 0; stray = 0; mask = 0;
    for (int i = 1; i <= 6 * FRAME; i++) begin
      step();
      if (vif.frame_start) fs_n++;
      if (vif.game_tick) begin
        gt_n++;
        if (!vif.frame_start) stray++;
        else mask = mask | (1 << fs_n);
      end
    end
    checks++;
    if (fs_n != 7) begin
      errors++;
      $display("FAIL frame_count: got %0d frame_starts expected 7", fs_n);
    end
    checks++;
    if (mask != ((1 << 3) | (1 << 6))) begin
      errors++;
      $display("FAIL tick_frames: got mask %0h expected 48", mask);
    end
    checks++;
    if (gt_n != 2 || stray != 0) begin
      errors++;
      $display("FAIL tick_width: got %0d tick cycles (%0d off frame_start) expected 2 (0)", gt_n, stray);
    end
  endtask

`ifdef VGA_TIMING_CELL_EN
  task automatic test_cell();
    run_to(40, 33);
    checks++;
    if (vif.cell_x_out !== 6'd1 || vif.cell_y_out !== 6'd1) begin
      errors++;
      $display("FAIL cell_active: got (%0d,%0d) expected (1,1)", vif.cell_x_out, vif.cell_y_out);
    end
    run_to(66, 33);
    checks++;
    if (vif.cell_x_out !== 6'd0 || vif.cell_y_out !== 6'd1) begin
      errors++;
      $display("FAIL cell_hblank: got (%0d,%0d) expected (0,1)", vif.cell_x_out, vif.cell_y_out);
    end
    run_to(33, 49);
    checks++;
    if (vif.cell_x_out !== 6'd1 || vif.cell_y_out !== 6'd0) begin
      errors++;
      $display("FAIL cell_vblank: got (%0d,%0d) expected (1,0)", vif.cell_x_out, vif.cell_y_out);
    end
  endtask
`endif

  task automatic test_mid_reset();
    int fs_cnt, gt_cnt, first_fs, first_gt;
    run_to(40, 30);
    rst = 1'b1;
    #1;
    checks++;
    if (vif.hcount_out !== 16'd0 || vif.vcount_out !== 16'd0 ||
        {vif.hsync_out, vif.vsync_out, vif.frame_start, vif.game_tick} !== 4'b1100) begin
      errors++;
      $display("FAIL async_reset: got (%0d,%0d) flags %b expected (0,0) flags 1100",
               vif.hcount_out, vif.vcount_out,
               {vif.hsync_out, vif.vsync_out, vif.frame_start, vif.game_tick});
    end
    repeat (3) step();
    checks++;
    if (vif.hcount_out !== 16'd0 || vif.vcount_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold: got (%0d,%0d) expected (0,0)", vif.hcount_out, vif.vcount_out);
    end
    @(negedge clk);
    rst = 1'b0;
    fs_cnt = 0; gt_cnt = 0; first_fs = -1; first_gt = -1;
    for (int n = 1; n <= TF * FRAME; n++) begin
      step();
      if (n == 1) begin
        checks++;
        if (vif.hcount_out !== 16'd1 || vif.vcount_out !== 16'd0) begin
          errors++;
          $display("FAIL restart: got (%0d,%0d) expected (1,0)", vif.hcount_out, vif.vcount_out);
        end
      end
      if (vif.frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = n;
      end
      if (vif.game_tick) begin
        gt_cnt++;
        if (first_gt < 0) first_gt = n;
      end
    end
    checks++;
    if (first_fs != FRAME || fs_cnt != TF) begin
      errors++;
      $display("FAIL restart_frames: first at %0d count %0d expected first at %0d count %0d",
               first_fs, fs_cnt, FRAME, TF);
    end
    checks++;
    if (first_gt != TF * FRAME || gt_cnt != 1) begin
      errors++;
      $display("FAIL restart_tick: first at %0d count %0d expected first at %0d count 1",
               first_gt, gt_cnt, TF * FRAME);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_game_tick();
`ifdef VGA_TIMING_CELL_EN
    test_cell();
`endif
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source of the pixel-timing interface consumed by every overlay stage (grid, snake, food, text): produces hcount_out/vcount_out, hsync_out/vsync_out and blanking for a 1024x768 @ 60 Hz raster at the 65 MHz pixel clock.
- Sits at the head of the video pipeline; downstream stages register rgb/sync and add one cycle each.
- Also issues a game-tick pulse every TICK_FRAMES frames for the snake movement logic.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BP, 160, horizontal back porch; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch; V_TOTAL = 806
- SYNC_ACTIVE, 1'b0, level of hsync/vsync while asserted (0 = negative polarity)
- TICK_FRAMES, 8, frames per game_tick pulse; legal range 1..255

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  asynchronous, active-high reset
- hcount_out  out  16  current pixel column, 0..H_TOTAL-1
- vcount_out  out  16  current line, 0..V_TOTAL-1
- hsync_out  out  1  horizontal sync, level per SYNC_ACTIVE
- vsync_out  out  1  vertical sync, level per SYNC_ACTIVE
- hblnk_out  out  1  1 when hcount_out >= H_ACTIVE
- vblnk_out  out  1  1 when vcount_out >= V_ACTIVE
- frame_start  out  1  one-cycle pulse when hcount_out=0 and vcount_out=0
- game_tick  out  1  one-cycle pulse, coincident with frame_start every TICK_FRAMES frames

Behaviour:
- Reset (async, active-high): hcount_out=0, vcount_out=0, hsync_out=vsync_out=~SYNC_ACTIVE, hblnk_out=vblnk_out=0, frame_start=0, game_tick=0, frame counter=0.
- All outputs are registered. Every output is a function of the same registered (hcount, vcount) pair: zero skew between counters and decodes. Decodes are computed from next-state counter values.
- H counter: increments every clk; at H_TOTAL-1 it wraps to 0.
- V counter: increments only when H wraps; at V_TOTAL-1 with H wrap it wraps to 0.
- hsync asserted for H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1 (1048..1183).
- vsync asserted for V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1 (771..776), on whole lines and aligned to h=0.
- Frame/tick logic:
  - frame_start is high during the single cycle where outputs read (0,0).
  - The first frame_start after reset release occurs one full frame after reset, not at reset.
  - An 8-bit frame counter increments on each frame_start and wraps to 0 after TICK_FRAMES-1.
  - game_tick = frame_start AND (frame counter == TICK_FRAMES-1 before the increment).
  - TICK_FRAMES=1: game_tick mirrors frame_start.
- Counter widths: internal counters are 11 bits (h) and 10 bits (v), zero-extended to 16 on output. Upper bits are always 0.
- Reset mid-frame: all state returns to reset values immediately. Counting resumes from (0,0) on the first clk edge after deassertion: outputs read (1,0).

Optional Feature:
- Macro: VGA_TIMING_CELL_EN.
- When defined, two extra registered ports are present:
  - cell_x_out (6 bits) = hcount/32
  - cell_y_out (6 bits) = vcount/32
- Both are cycle-aligned with hcount_out/vcount_out, reset to 0, and hold 0 whenever the corresponding blank is high. This lets overlay stages drop their own dividers.
- When undefined, the ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - the 1024x768 timing constants (H_/V_ ACTIVE, FP, SYNC, BP, TOTAL)
  - CELL_SIZE=32, GRID_COLS=32, GRID_ROWS=24
  - the sync polarity constant
- These are reused by the grid and snake stages.
- One natural sub-module: vga_axis_counter, a parameterised wrap counter with sync/blank decode instantiated once for H and once for V (V stepped by the H wrap enable).
- Frame/tick logic stays in the top.

Test Plan:
- Reset held 10 cycles, released -> outputs (1,0) on first edge; hsync=vsync=1; blanks 0; no frame_start until cycle 1344*806=1,083,264.
- Run one line -> hblnk rises at h=1024, hsync low for exactly 136 cycles from h=1048, h wraps 1343->0 with v 0->1.
- Run to v=770..777 -> vsync low exactly from (0,771) through (1343,776) = 6*1344 cycles; vblnk high v=768..805; v wraps 805->0 at h wrap.
- TICK_FRAMES=3, run 7 frames -> game_tick on frames 3 and 6 only, each coincident with frame_start, width 1 cycle.
- Assert rst at (500,300) for 3 cycles -> immediate outputs (0,0) sync inactive; counting restarts; frame counter cleared (next game_tick after TICK_FRAMES full frames).
- With VGA_TIMING_CELL_EN: at (95,64) -> cell_x=2, cell_y=2; at (1030,10) -> cell_x=0 (hblnk); at (31,767) -> cell_x=0, cell_y=23.
